// File: rtl/sawtooth_pkg.sv
// Shared definitions for the sawtooth configuration sequencer and counter datapath:
// state codes, default width, error indication level and bound reset values.
package sawtooth_pkg;

    localparam int unsigned DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_N1 = 3'd1,
        GET_N2 = 3'd2,
        CHECK  = 3'd3,
        LOAD   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } state_e;

    // Error indication drives every segment line to this level.
    localparam logic ERR_IND_LVL = 1'b1;

    localparam int unsigned N1_RST = 0;
    localparam int unsigned N2_RST = 1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce counter and a single-cycle
// pulse on each accepted 0->1 transition of the stable level.
module btn_debounce #(
    parameter int DEB_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

    logic       sync0;
    logic       sync1;
    logic       stab;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            stab  <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
            press <= 1'b0;
            // Any sample that agrees with the stable level restarts the run.
            if (sync1 == stab) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stab  <= sync1;
                cnt   <= '0;
                press <= sync1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sawtooth_cfg_ctrl.sv
// Configuration sequencer for the sawtooth counter: captures N1/N2, validates,
// loads via req/ack and gates counting. Optional macro SAWTOOTH_AUTO_SWAP_EN.
module sawtooth_cfg_ctrl
    import sawtooth_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int DEB_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 8,
    parameter int ERR_HOLD    = 4
) (
    input  logic          clc_i,
    input  logic          rst_i,
    input  logic          btn_i,
    input  logic [DW-1:0] din_i,
    input  logic          cfg_ack_i,
    input  logic [DW-1:0] cnt_i,
    output logic [DW-1:0] cfg_n1_o,
    output logic [DW-1:0] cfg_n2_o,
    output logic          cfg_req_o,
    output logic          run_o,
    output logic          err_o,
    output logic [DW-1:0] dind_o,
    output logic [2:0]    state_o
);

    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] ERR_LAST = 8'(ERR_HOLD - 1);

    state_e        state_q, state_nxt;
    logic [7:0]    tmr_q, tmr_nxt;
    logic          err_cmp_q, err_cmp_nxt;
    logic [DW-1:0] sh_n1, sh_n2;
    logic [DW-1:0] lo, hi;
    logic [DW-1:0] n1_nxt, n2_nxt, dind_nxt;
    logic          press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clc_i),
        .rst_n (rst_i),
        .btn   (btn_i),
        .press (press)
    );

`ifdef SAWTOOTH_AUTO_SWAP_EN
    assign lo = (sh_n2 < sh_n1) ? sh_n2 : sh_n1;
    assign hi = (sh_n2 < sh_n1) ? sh_n1 : sh_n2;
`else
    assign lo = sh_n1;
    assign hi = sh_n2;
`endif

    always_comb begin
        state_nxt   = state_q;
        tmr_nxt     = '0;
        err_cmp_nxt = err_cmp_q;
        n1_nxt      = cfg_n1_o;
        n2_nxt      = cfg_n2_o;
        dind_nxt    = dind_o;
        case (state_q)
            IDLE:   if (press) state_nxt = GET_N1;
            GET_N1: if (press) state_nxt = GET_N2;
            GET_N2: if (press) state_nxt = CHECK;
            CHECK: begin
                if (hi > lo) begin
                    state_nxt = LOAD;
                    n1_nxt    = lo;
                    n2_nxt    = hi;
                end else begin
                    state_nxt   = ERR;
                    err_cmp_nxt = 1'b1;
                end
            end
            LOAD: begin
                // An ack sampled on the final timeout cycle still wins.
                if (cfg_ack_i) begin
                    state_nxt = RUN;
                end else if (tmr_q == ACK_LAST) begin
                    state_nxt   = ERR;
                    err_cmp_nxt = 1'b0;
                end else begin
                    tmr_nxt = tmr_q + 8'd1;
                end
            end
            RUN:    if (press) state_nxt = GET_N1;
            ERR: begin
                if (tmr_q == ERR_LAST) state_nxt = err_cmp_q ? GET_N2 : IDLE;
                else                   tmr_nxt   = tmr_q + 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
        case (state_nxt)
            IDLE:           dind_nxt = '0;
            GET_N1, GET_N2: dind_nxt = din_i;
            RUN:            dind_nxt = cnt_i;
            ERR:            dind_nxt = {DW{ERR_IND_LVL}};
            default:        ;
        endcase
    end

    always_ff @(posedge clc_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            err_cmp_q <= 1'b0;
            cfg_n1_o  <= DW'(N1_RST);
            cfg_n2_o  <= DW'(N2_RST);
            cfg_req_o <= 1'b0;
            run_o     <= 1'b0;
            err_o     <= 1'b0;
            dind_o    <= '0;
        end else begin
            state_q   <= state_nxt;
            tmr_q     <= tmr_nxt;
            err_cmp_q <= err_cmp_nxt;
            cfg_n1_o  <= n1_nxt;
            cfg_n2_o  <= n2_nxt;
            cfg_req_o <= (state_nxt == LOAD);
            run_o     <= (state_nxt == RUN);
            err_o     <= (state_nxt == ERR);
            dind_o    <= dind_nxt;
        end
    end

    // Shadow bounds are pure data; they are always written before CHECK reads them.
    always_ff @(posedge clc_i) begin
        if (press && state_q == GET_N1) sh_n1 <= din_i;
        if (press && state_q == GET_N2) sh_n2 <= din_i;
    end

    assign state_o = state_q;

endmodule

// File: doc/sawtooth_cfg_ctrl.md
Name: sawtooth_cfg_ctrl

Overview:
Configuration sequencer in front of the sawtooth counter datapath. Conditions the raw select button and captures N1/N2 from the data switches. Validates N2 > N1, then loads the pair into the counter through a req/ack handshake and gates counting with run_o. Also drives the 7-segment indication and state code.

Parameters:
DW, 8, data width of N1/N2/switches/indication
DEB_CYCLES, 2, clock cycles the synchronised button must be stable before a level change is accepted (1..15)
ACK_TIMEOUT, 8, max cycles cfg_req_o waits for cfg_ack_i before error (1..255)
ERR_HOLD, 4, cycles ERR state is held before recovery (1..255)

Ports:
clc_i  in  1  system clock (4 Hz board clock)
rst_i  in  1  asynchronous active-low reset
btn_i  in  1  raw select button, asynchronous, active-high
din_i  in  DW  data select switches
cfg_ack_i  in  1  datapath load acknowledge
cnt_i  in  DW  current counter value from datapath, for indication
cfg_n1_o  out  DW  registered lower bound
cfg_n2_o  out  DW  registered upper bound
cfg_req_o  out  1  load request, held until ack or timeout
run_o  out  1  counter enable
err_o  out  1  error flag
dind_o  out  DW  indication data
state_o  out  3  current state code

Behaviour:
- Clocking/reset: one clock, clc_i. Reset is rst_i, asynchronous, active-low.
- Reset values: state IDLE; cfg_n1_o=0; cfg_n2_o=1; cfg_req_o=0; run_o=0; err_o=0; dind_o=0; state_o=0. Debounce counter, synchroniser and timers are all 0.
- Button path:
  - 2-flop synchroniser, then debounce. The stable level updates only after DEB_CYCLES consecutive equal samples differ from it.
  - press = single-cycle pulse on the 0->1 transition of the stable level.
  - Latency from a clean raw rise to press: 2+DEB_CYCLES cycles.
- States (code): IDLE=0, GET_N1=1, GET_N2=2, CHECK=3, LOAD=4, RUN=5, ERR=6.
- IDLE: dind_o=0. press -> GET_N1.
- GET_N1: dind_o follows din_i, registered (1-cycle lag). press -> latch din_i into the N1 shadow, go to GET_N2.
- GET_N2: same as GET_N1, latching the N2 shadow. press -> CHECK.
- CHECK: one cycle. Shadow N2 > N1 (unsigned) -> LOAD. Otherwise -> ERR.
- LOAD:
  - cfg_req_o=1 from state entry. cfg_n1_o/cfg_n2_o are updated from the shadows on LOAD entry and are stable while req is high.
  - Sample cfg_ack_i=1 -> cfg_req_o=0 next cycle, go to RUN.
  - ACK_TIMEOUT cycles without ack -> ERR, with cfg_req_o dropped.
  - Ack arriving on the timeout cycle wins (go to RUN).
- RUN: run_o=1, dind_o=cnt_i registered. press -> GET_N1, with run_o=0 in the same cycle the state changes. cfg_n1_o/cfg_n2_o are retained.
- ERR:
  - err_o=1, dind_o all ones, run_o=0.
  - After ERR_HOLD cycles: from a compare failure -> GET_N2 (N1 kept); from a timeout -> IDLE.
  - press in ERR is ignored.
- Press priority: press during CHECK or LOAD is discarded.
- Boundaries:
  - N1=N2 is an error.
  - N1=0, N2=2^DW-1 is legal.
  - Reset mid-LOAD drops cfg_req_o immediately (async).
- state_o = registered state code.

Optional Feature:
- Macro: SAWTOOTH_AUTO_SWAP_EN.
- Defined: in CHECK, N2 < N1 swaps the shadows (cfg_n1_o gets the smaller value) and proceeds to LOAD. N2 = N1 is still an error.
- Not defined: any N2 <= N1 goes to ERR as described above.

Decomposition:
- Package sawtooth_pkg holds:
  - state encoding constants IDLE..ERR (3-bit);
  - default DW;
  - error indication pattern;
  - reset defaults N1_RST=0, N2_RST=1 (shared with the counter datapath).
- Sub-module btn_debounce: synchroniser, debounce counter and rising-edge pulse, parameterised by DEB_CYCLES. It is reused for any further buttons.

Test Plan:
- Reset, then raw btn_i high for 5 cycles: press pulses exactly once, 4 cycles after the rise; state 0->1. A 1-cycle glitch on btn_i produces no press.
- din_i=10 press, din_i=50 press, ack returned 2 cycles after req: cfg_n1_o=10, cfg_n2_o=50, cfg_req_o high for 3 cycles, then run_o=1 and state_o=5.
- din_i=50 then 10:
  - without macro: err_o=1 for 4 cycles, dind_o=8'hFF, then state_o=2 with N1 shadow still 50;
  - with SAWTOOTH_AUTO_SWAP_EN: cfg_n1_o=10, cfg_n2_o=50, LOAD entered.
- cfg_ack_i held 0: cfg_req_o drops after 8 cycles, ERR for 4 cycles, then IDLE. A separate run with ack on cycle 8 goes to RUN.
- In RUN with cnt_i=33, press: dind_o showed 33, and run_o=0 in the same cycle state_o becomes 1.
- rst_i asserted low mid-LOAD: cfg_req_o=0, state_o=0, cfg_n1_o=0, cfg_n2_o=1 immediately without a clock edge.
